// File: rtl/count_seq_if.sv
// Control, status and counter-side signals of count_sequencer grouped as one bus.
// master = requester/counter side, slave = the sequencer itself.
interface count_seq_if #(
  parameter int WIDTH = 32
);
  logic             start_in;
  logic [WIDTH-1:0] run_len_in;
  logic             pause_in;
  logic             abort_in;
  logic [WIDTH-1:0] cnt_count_in;
  logic             cnt_rst_out;
  logic             cnt_incr_out;
  logic             busy_out;
  logic             done_out;
  logic             aborted_out;
  logic [WIDTH-1:0] issued_out;
  logic             err_out;

  modport master (
    output start_in, run_len_in, pause_in, abort_in, cnt_count_in,
    input  cnt_rst_out, cnt_incr_out, busy_out, done_out, aborted_out,
           issued_out, err_out
  );

  modport slave (
    input  start_in, run_len_in, pause_in, abort_in, cnt_count_in,
    output cnt_rst_out, cnt_incr_out, busy_out, done_out, aborted_out,
           issued_out, err_out
  );
endinterface

// File: rtl/count_sequencer.sv
// Sequences a downstream counter through clear + N increments with pause/abort.
// Optional COUNT_SEQ_CHECK_EN adds a sticky end-of-run count mismatch flag.
module count_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  count_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] issued_q, issued_d;
  logic             aborted_q, aborted_d;
  logic             incr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    aborted_d = 1'b0;
    // Abort outranks both pause and completion, so it gates the increment too.
    incr      = (state_q == RUN) && !bus.pause_in && !bus.abort_in;

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          len_d    = bus.run_len_in;
          issued_d = '0;
          state_d  = (bus.run_len_in != '0) ? CLEAR : DONE;
        end
      end
      CLEAR: begin
        issued_d = '0;
        if (bus.abort_in) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort_in) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (incr) begin
          issued_d = issued_q + {{(WIDTH-1){1'b0}}, 1'b1};
          if (issued_q == len_q - {{(WIDTH-1){1'b0}}, 1'b1})
            state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cnt_rst_out  = (state_q == CLEAR);
  assign bus.cnt_incr_out = incr;
  assign bus.busy_out     = (state_q != IDLE);
  assign bus.done_out     = (state_q == DONE);
  assign bus.aborted_out  = aborted_q;
  assign bus.issued_out   = issued_q;

`ifdef COUNT_SEQ_CHECK_EN
  logic err_q, err_d;

  // Zero-length runs never touch the counter, so they are not checked.
  always_comb begin
    err_d = err_q;
    if ((state_q == DONE) && (len_q != '0) && (bus.cnt_count_in != len_q))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign bus.err_out = err_q;
`else
  logic unused_cnt_count;
  assign unused_cnt_count = ^bus.cnt_count_in;
  assign bus.err_out      = 1'b0;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer with a behavioural counter model.
module tb_count_sequencer;
  localparam int W = 32;
`ifdef COUNT_SEQ_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  count_seq_if #(.WIDTH(W)) bus ();
  count_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Downstream counter model, optionally overridden to inject a wrong count
  logic [W-1:0] cnt_model = '0;
  logic         force_en  = 1'b0;
  logic [W-1:0] force_val = '0;
  always @(posedge clk) begin
    if (bus.cnt_rst_out)       cnt_model <= '0;
    else if (bus.cnt_incr_out) cnt_model <= cnt_model + 1;
  end
  assign bus.cnt_count_in = force_en ? force_val : cnt_model;

  int n_vec = 0;
  int n_bad = 0;

  logic     sv [64];
  logic     pv [64];
  logic     av [64];
  int       lv [64];
  logic     r_rst [64], r_inc [64], r_done [64], r_abt [64], r_busy [64], r_err [64];
  logic [W-1:0] r_iss [64];
  int tot_rst, tot_inc, tot_done, tot_abt;

  task automatic clr_stim();
    for (int i = 0; i < 64; i++) begin
      sv[i] = 1'b0; pv[i] = 1'b0; av[i] = 1'b0; lv[i] = 0;
    end
  endtask

  // Cycle c: drive stimulus at edge+2, record outputs at edge+3.
  task automatic observe(input int n);
    tot_rst = 0; tot_inc = 0; tot_done = 0; tot_abt = 0;
    for (int c = 0; c < n; c++) begin
      bus.start_in   = sv[c];
      bus.pause_in   = pv[c];
      bus.abort_in   = av[c];
      bus.run_len_in = W'(lv[c]);
      #1;
      r_rst[c]  = bus.cnt_rst_out;  r_inc[c]  = bus.cnt_incr_out;
      r_done[c] = bus.done_out;     r_abt[c]  = bus.aborted_out;
      r_busy[c] = bus.busy_out;     r_err[c]  = bus.err_out;
      r_iss[c]  = bus.issued_out;
      tot_rst  += int'(r_rst[c]);  tot_inc += int'(r_inc[c]);
      tot_done += int'(r_done[c]); tot_abt += int'(r_abt[c]);
      @(posedge clk); #2;
    end
    bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.abort_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start_in = 1'b0; bus.pause_in = 1'b0; bus.abort_in = 1'b0;
    bus.run_len_in = '0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({bus.cnt_rst_out, bus.cnt_incr_out, bus.busy_out, bus.done_out,
         bus.aborted_out, bus.err_out} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.cnt_rst_out, bus.cnt_incr_out,
               bus.busy_out, bus.done_out, bus.aborted_out, bus.err_out});
    end
    n_vec++;
    if (bus.issued_out !== '0) begin
      n_bad++; $display("FAIL reset_issued: got %0d want 0", bus.issued_out);
    end
    rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_basic();
    int first, last;
    clr_stim();
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 6;
    observe(12);
    first = -1; last = -1;
    for (int c = 0; c < 12; c++)
      if (r_inc[c]) begin
        if (first < 0) first = c;
        last = c;
      end
    n_vec++;
    if (tot_rst !== 1 || r_rst[1] !== 1'b1) begin
      n_bad++; $display("FAIL basic_clear: got %0d cycles (c1=%b) want 1 at c1", tot_rst, r_rst[1]);
    end
    n_vec++;
    if (tot_inc !== 6 || first !== 2 || last !== 7) begin
      n_bad++; $display("FAIL basic_incr: got %0d incr c%0d..c%0d want 6 at c2..c7", tot_inc, first, last);
    end
    n_vec++;
    if (tot_done !== 1 || r_done[8] !== 1'b1) begin
      n_bad++; $display("FAIL basic_done: got %0d pulses (c8=%b) want 1 at c8", tot_done, r_done[8]);
    end
    n_vec++;
    if (r_iss[8] !== W'(6) || cnt_model !== W'(6)) begin
      n_bad++; $display("FAIL basic_count: got issued %0d counter %0d want 6/6", r_iss[8], cnt_model);
    end
    n_vec++;
    if (r_busy[0] !== 1'b0 || r_busy[1] !== 1'b1 || r_busy[9] !== 1'b0 || r_err[9] !== 1'b0) begin
      n_bad++; $display("FAIL basic_busy_err: got busy %b%b%b err %b want 010 err 0",
                        r_busy[0], r_busy[1], r_busy[9], r_err[9]);
    end
  endtask

  task automatic test_pause();
    clr_stim();
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 4;
    for (int i = 4; i <= 6; i++) pv[i] = 1'b1;
    observe(14);
    n_vec++;
    if (tot_inc !== 4) begin
      n_bad++; $display("FAIL pause_incr: got %0d want 4", tot_inc);
    end
    n_vec++;
    if (tot_done !== 1 || r_done[9] !== 1'b1) begin
      n_bad++; $display("FAIL pause_done: got %0d pulses (c9=%b) want 1 at c9", tot_done, r_done[9]);
    end
    for (int c = 4; c <= 6; c++) begin
      n_vec++;
      if (r_iss[c] !== W'(2) || r_inc[c] !== 1'b0) begin
        n_bad++; $display("FAIL pause_hold c%0d: got issued %0d incr %b want 2/0", c, r_iss[c], r_inc[c]);
      end
    end
  endtask

  task automatic test_abort();
    clr_stim();
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 10;
    av[5]  = 1'b1;
    av[10] = 1'b1;  // abort while idle must be ignored
    observe(16);
    n_vec++;
    if (tot_inc !== 3 || r_inc[5] !== 1'b0) begin
      n_bad++; $display("FAIL abort_incr: got %0d (c5=%b) want 3 and 0", tot_inc, r_inc[5]);
    end
    n_vec++;
    if (tot_abt !== 1 || r_abt[6] !== 1'b1) begin
      n_bad++; $display("FAIL abort_pulse: got %0d (c6=%b) want 1 at c6", tot_abt, r_abt[6]);
    end
    n_vec++;
    if (tot_done !== 0) begin
      n_bad++; $display("FAIL abort_nodone: got %0d want 0", tot_done);
    end
    n_vec++;
    if (r_iss[6] !== W'(3) || r_busy[6] !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: got issued %0d busy %b want 3/0", r_iss[6], r_busy[6]);
    end
  endtask

  task automatic test_zero_len();
    clr_stim();
    sv[0] = 1'b1;
    av[1] = 1'b1;  // abort in DONE must be ignored
    observe(5);
    n_vec++;
    if (tot_done !== 1 || r_done[1] !== 1'b1 || r_busy[1] !== 1'b1 || r_busy[2] !== 1'b0) begin
      n_bad++; $display("FAIL zero_done: got %0d (c1=%b busy %b%b) want 1 at c1 busy 10",
                        tot_done, r_done[1], r_busy[1], r_busy[2]);
    end
    n_vec++;
    if (tot_rst !== 0 || tot_inc !== 0 || tot_abt !== 0) begin
      n_bad++; $display("FAIL zero_quiet: got rst %0d incr %0d abt %0d want 0/0/0", tot_rst, tot_inc, tot_abt);
    end
  endtask

  task automatic test_busy_start();
    clr_stim();
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 5;
    sv[3] = 1'b1; lv[3] = 9;
    observe(12);
    n_vec++;
    if (tot_inc !== 5 || tot_rst !== 1) begin
      n_bad++; $display("FAIL busy_start_incr: got incr %0d rst %0d want 5/1", tot_inc, tot_rst);
    end
    n_vec++;
    if (tot_done !== 1 || r_done[7] !== 1'b1 || r_iss[7] !== W'(5)) begin
      n_bad++; $display("FAIL busy_start_done: got %0d (c7=%b iss %0d) want 1 at c7 iss 5",
                        tot_done, r_done[7], r_iss[7]);
    end
  endtask

  task automatic test_check();
    clr_stim();
    force_en = 1'b1; force_val = W'(4);
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 5;
    observe(10);
    force_en = 1'b0;
    n_vec++;
    if (r_done[7] !== 1'b1 || r_err[7] !== 1'b0 || r_err[8] !== ERR_EXP) begin
      n_bad++; $display("FAIL check_set: got done %b err %b->%b want 1 0->%b",
                        r_done[7], r_err[7], r_err[8], ERR_EXP);
    end
    clr_stim();
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 2;
    observe(6);
    n_vec++;
    if (r_err[5] !== ERR_EXP || tot_done !== 1) begin
      n_bad++; $display("FAIL check_sticky: got err %b done %0d want %b/1", r_err[5], tot_done, ERR_EXP);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.err_out !== 1'b0) begin
      n_bad++; $display("FAIL check_clear: got %b want 0", bus.err_out);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_async_reset();
    clr_stim();
    sv[0] = 1'b1;
    for (int i = 0; i < 64; i++) lv[i] = 6;
    observe(5);
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.cnt_rst_out, bus.cnt_incr_out, bus.busy_out, bus.done_out,
         bus.aborted_out, bus.err_out} !== 6'b0 || bus.issued_out !== '0) begin
      n_bad++; $display("FAIL async_reset: got ctrl %b issued %0d want 000000/0",
                        {bus.cnt_rst_out, bus.cnt_incr_out, bus.busy_out, bus.done_out,
                         bus.aborted_out, bus.err_out}, bus.issued_out);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    clr_stim();
    observe(6);
    n_vec++;
    if (tot_done !== 0 || tot_abt !== 0 || tot_inc !== 0 || r_busy[0] !== 1'b0 || r_busy[5] !== 1'b0) begin
      n_bad++; $display("FAIL async_after: got done %0d abt %0d incr %0d busy %b%b want 0/0/0 00",
                        tot_done, tot_abt, tot_inc, r_busy[0], r_busy[5]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_abort();
    test_zero_len();
    test_busy_start();
    test_check();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the run length, issued count and counter feedback.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset (asserted at 0).
REQ-004 start_in  input  1  SHALL request a counting run.
REQ-005 run_len_in  input  WIDTH  SHALL give the number of increments per run, sampled when start is accepted.
REQ-006 pause_in  input  1  SHALL suspend increments while high.
REQ-007 abort_in  input  1  SHALL terminate the current run.
REQ-008 cnt_count_in  input  WIDTH  SHALL carry the downstream counter's registered count.
REQ-009 cnt_rst_out  output  1  SHALL be the active-high synchronous clear to the counter.
REQ-010 cnt_incr_out  output  1  SHALL be the increment enable to the counter.
REQ-011 busy_out  output  1  SHALL be high in any state other than IDLE.
REQ-012 done_out  output  1  SHALL be a one-cycle pulse on run completion.
REQ-013 aborted_out  output  1  SHALL be a one-cycle pulse on abort.
REQ-014 issued_out  output  WIDTH  SHALL report increments issued in the current run.
REQ-015 err_out  output  1  SHALL be a sticky count-mismatch flag.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, DONE.
REQ-017 IDLE: start_in=1 with run_len_in!=0 SHALL latch run_len_in and go to CLEAR; start_in=1 with run_len_in=0 SHALL go directly to DONE with no increments.
REQ-018 CLEAR: cnt_rst_out SHALL be 1 for exactly this one cycle; issued count SHALL clear to 0; next state SHALL be RUN.
REQ-019 RUN: cnt_incr_out SHALL equal (state==RUN && !pause_in && !abort_in), combinationally; each cycle it is 1 the issued count SHALL increment.
REQ-020 RUN: when cnt_incr_out=1 and issued count equals latched length minus 1, next state SHALL be DONE; issued_out SHALL then equal the latched length.
REQ-021 DONE: done_out SHALL be 1 for that single cycle; next state SHALL be IDLE.
REQ-022 start_in while busy_out=1 SHALL be ignored; latched length SHALL not change mid-run.
REQ-023 abort_in in CLEAR or RUN SHALL force IDLE on the next edge, suppress cnt_incr_out that cycle and pulse aborted_out in the following cycle; abort SHALL take priority over pause and completion.
REQ-024 abort_in in IDLE or DONE SHALL have no effect.
REQ-025 Pause held indefinitely SHALL hold RUN with issued count frozen; no timeout.
REQ-026 Issued count SHALL never exceed the latched length; arithmetic SHALL be unsigned WIDTH-bit, no wrap possible.

Reset
REQ-027 rst=0 SHALL immediately force IDLE and drive cnt_rst_out=0, cnt_incr_out=0, busy_out=0, done_out=0, aborted_out=0, issued_out=0, err_out=0, latched length=0.
REQ-028 Reset mid-run SHALL discard the run without done_out or aborted_out pulses.

Configuration
REQ-029 With macro COUNT_SEQ_CHECK_EN defined, in DONE (non-zero length runs only) cnt_count_in SHALL be compared to the latched length and err_out SHALL set on mismatch, clearing only on reset.
REQ-030 Without COUNT_SEQ_CHECK_EN, err_out SHALL be tied 0 and cnt_count_in SHALL be unused.

Verification
REQ-031 Basic run: run_len=6, start for 1 cycle, counter attached -> one cnt_rst_out cycle, 6 consecutive cnt_incr_out cycles, done_out one cycle later, count=6, err_out=0.
REQ-032 Pause: run_len=4, pause_in high for 3 cycles after 2nd increment -> exactly 4 increments total, done_out delayed 3 cycles, issued_out holds 2 during pause.
REQ-033 Abort: run_len=10, abort_in after 3rd increment -> no further increments, aborted_out pulse, no done_out, issued_out=3, back to IDLE.
REQ-034 Zero length and busy start: run_len=0 -> done_out next cycle, no cnt_rst_out/cnt_incr_out; start_in during a run_len=5 run -> ignored, exactly 5 increments.
REQ-035 Check (COUNT_SEQ_CHECK_EN): run_len=5 with cnt_count_in forced to 4 -> err_out=1 after DONE and stays 1 until rst=0.
REQ-036 Async reset: rst=0 asserted mid-RUN between clock edges -> all outputs 0 immediately, IDLE after release, no pulses.
